// File: rtl/lcd_write_sequencer.sv
// HD44780-style LCD sequencer: runs the power-up init ROM, then serialises single-byte
// command/data writes onto the LCD pins, timing every phase in units of an external tick.
`timescale 1ns/1ps
module lcd_write_sequencer #(
  parameter int CNT_W         = 16,
  parameter int POWERUP_TICKS = 3750,
  parameter int SETUP_TICKS   = 1,
  parameter int E_HIGH_TICKS  = 1,
  parameter int EXEC_TICKS    = 10,
  parameter int CLEAR_TICKS   = 410
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       tick,
  output logic       timer_enable,
  input  logic       req,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       ack,
  output logic       busy,
  output logic       init_done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);

  typedef enum logic [2:0] {PWR_WAIT, SETUP, E_HIGH, HOLD, EXEC_WAIT, IDLE} state_t;

  localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(POWERUP_TICKS - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_TICKS - 1);
  localparam logic [CNT_W-1:0] EHIGH_LAST = CNT_W'(E_HIGH_TICKS - 1);
  localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(EXEC_TICKS - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_TICKS - 1);

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_rom = 8'h38;
      3'd3:             init_rom = 8'h0C;
      3'd4:             init_rom = 8'h01;
      default:          init_rom = 8'h06;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, phase_last;
  logic [2:0]       idx_q, idx_d;
  logic             lcd_e_q, lcd_e_d, lcd_rs_q, lcd_rs_d;
  logic [7:0]       lcd_data_q, lcd_data_d;
  logic             ack_q, ack_d, init_done_q, init_done_d, ten_q, ten_d;
  logic             is_clear;

  // Clear and home need the long execution wait
  assign is_clear = !lcd_rs_q && (lcd_data_q == 8'h01 || lcd_data_q == 8'h02);

  always_comb begin
    phase_last = '0;
    case (state_q)
      PWR_WAIT:  phase_last = PWR_LAST;
      SETUP:     phase_last = SETUP_LAST;
      E_HIGH:    phase_last = EHIGH_LAST;
      HOLD:      phase_last = '0;
      EXEC_WAIT: phase_last = is_clear ? CLEAR_LAST : EXEC_LAST;
      default:   phase_last = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    lcd_e_d     = lcd_e_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_data_d  = lcd_data_q;
    ack_d       = 1'b0;
    init_done_d = init_done_q;
    if (state_q == IDLE) begin
      if (req) begin
        state_d    = SETUP;
        lcd_rs_d   = req_rs;
        lcd_data_d = req_data;
        ack_d      = 1'b1;
        cnt_d      = '0;
      end
    end else if (tick) begin
      if (cnt_q == phase_last) begin
        cnt_d = '0;
        case (state_q)
          PWR_WAIT: begin
            state_d    = SETUP;
            idx_d      = 3'd0;
            lcd_rs_d   = 1'b0;
            lcd_data_d = init_rom(3'd0);
          end
          SETUP: begin
            state_d = E_HIGH;
            lcd_e_d = 1'b1;
          end
          E_HIGH: begin
            state_d = HOLD;
            lcd_e_d = 1'b0;
          end
          HOLD: state_d = EXEC_WAIT;
          EXEC_WAIT: begin
            if (!init_done_q && idx_q < 3'd5) begin
              state_d    = SETUP;
              idx_d      = idx_q + 3'd1;
              lcd_rs_d   = 1'b0;
              lcd_data_d = init_rom(idx_q + 3'd1);
            end else begin
              state_d     = IDLE;
              init_done_d = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    ten_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= '0;
      idx_q       <= '0;
      lcd_e_q     <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_data_q  <= 8'h00;
      ack_q       <= 1'b0;
      init_done_q <= 1'b0;
      ten_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      lcd_e_q     <= lcd_e_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_data_q  <= lcd_data_d;
      ack_q       <= ack_d;
      init_done_q <= init_done_d;
      ten_q       <= ten_d;
    end
  end

  assign timer_enable = ten_q;
  assign ack          = ack_q;
  assign busy         = (state_q != IDLE);
  assign init_done    = init_done_q;
  assign lcd_e        = lcd_e_q;
  assign lcd_rs       = lcd_rs_q;
  assign lcd_rw       = 1'b0;
  assign lcd_data     = lcd_data_q;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Bench for lcd_write_sequencer: an event recorder logs E edges, busy falls and acks in
// clocks and ticks; directed and random writes are checked against tick-count arithmetic.
`timescale 1ns/1ps
module tb_lcd_write_sequencer;
  localparam int P = 4, S = 1, EH = 1, X = 2, C = 3;

  logic       clock = 1'b0, rst = 1'b0, tick = 1'b0, req = 1'b0, req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       timer_enable, ack, busy, init_done, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  lcd_write_sequencer #(.CNT_W(16), .POWERUP_TICKS(P), .SETUP_TICKS(S), .E_HIGH_TICKS(EH),
                        .EXEC_TICKS(X), .CLEAR_TICKS(C)) dut (
    .clock(clock), .rst(rst), .tick(tick), .timer_enable(timer_enable), .req(req),
    .req_rs(req_rs), .req_data(req_data), .ack(ack), .busy(busy), .init_done(init_done),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data));

  always #5 clock = ~clock;

  int total = 0, bad = 0;
  int cyc = 0, tcnt = 0;
  bit tick_run = 1'b1;
  int div = 0;
  logic [7:0] rom [0:5] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (tick) tcnt <= tcnt + 1;
  end

  // Tick every 5 clocks while running
  initial begin
    forever begin
      @(negedge clock);
      if (tick_run) begin
        div  = (div + 1) % 5;
        tick = (div == 0);
      end else begin
        tick = 1'b0;
      end
    end
  end

  typedef struct {int cyc; int t; logic rs; logic [7:0] d;} ev_t;
  ev_t rise_q[$], fall_q[$], bfall_q[$], ack_q[$];
  logic e_prev = 1'b0, b_prev = 1'b1;
  int rw_bad = 0, ack_bad = 0;

  function automatic ev_t mk();
    ev_t e;
    e.cyc = cyc; e.t = tcnt; e.rs = lcd_rs; e.d = lcd_data;
    return e;
  endfunction

  always @(negedge clock) begin
    if (lcd_e && !e_prev) rise_q.push_back(mk());
    if (!lcd_e && e_prev) fall_q.push_back(mk());
    if (!busy && b_prev) bfall_q.push_back(mk());
    if (ack) begin
      ack_q.push_back(mk());
      if (b_prev) ack_bad++;
    end
    if (lcd_rw !== 1'b0) rw_bad++;
    e_prev = lcd_e;
    b_prev = busy;
  end

  function automatic int wt(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02)) ? C : X;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic clear_q();
    rise_q.delete(); fall_q.delete(); bfall_q.delete(); ack_q.delete();
  endtask

  task automatic wait_bfall(input int count, input int limit);
    int n = 0;
    while (bfall_q.size() < count && n < limit) begin
      step(1);
      n++;
    end
    chk("busy_fall_seen", 32'(bfall_q.size() >= count), 1);
  endtask

  task automatic check_init(input int base);
    wait_bfall(1, 1000);
    chk("init_done_at_idle", init_done, 1);
    chk("busy_at_idle", busy, 0);
    chk("timer_en_idle", timer_enable, 0);
    chk("init_no_ack", ack_q.size(), 0);
    chk("init_rises", rise_q.size(), 6);
    chk("init_falls", fall_q.size(), 6);
    if (rise_q.size() == 6 && fall_q.size() == 6 && bfall_q.size() >= 1) begin
      chk("powerup_ticks", rise_q[0].t - base, P + S);
      for (int k = 0; k < 6; k++) begin
        chk("init_rs", rise_q[k].rs, 0);
        chk("init_byte", rise_q[k].d, rom[k]);
        chk("init_e_high", fall_q[k].t - rise_q[k].t, EH);
        if (k < 5) chk("init_gap", rise_q[k+1].t - fall_q[k].t, 1 + wt(1'b0, rom[k]) + S);
      end
      chk("init_last_wait", bfall_q[0].t - fall_q[5].t, 1 + wt(1'b0, rom[5]));
    end
  endtask

  task automatic write_and_check(input logic rs, input logic [7:0] d, input bit freeze);
    int at;
    clear_q();
    if (freeze) begin
      tick_run = 1'b0;
      step(2);
    end
    req = 1'b1; req_rs = rs; req_data = d;
    step(1);
    chk("ack_latency", ack, 1);
    chk("busy_on_accept", busy, 1);
    chk("latched_rs", lcd_rs, rs);
    chk("latched_data", lcd_data, d);
    req = 1'b0;
    at = (ack_q.size() > 0) ? ack_q[0].t : 0;
    if (freeze) begin
      step(40);
      chk("frozen_e", lcd_e, 0);
      chk("frozen_busy", busy, 1);
      chk("frozen_data", lcd_data, d);
      chk("frozen_ten", timer_enable, 1);
      tick_run = 1'b1;
    end else begin
      step(1);
      chk("ack_one_cycle", ack, 0);
    end
    wait_bfall(1, 500);
    chk("wr_rises", rise_q.size(), 1);
    chk("wr_acks", ack_q.size(), 1);
    if (rise_q.size() == 1 && fall_q.size() == 1 && bfall_q.size() == 1) begin
      chk("wr_rs", rise_q[0].rs, rs);
      chk("wr_data", rise_q[0].d, d);
      chk("wr_setup", rise_q[0].t - at, S);
      chk("wr_e_high", fall_q[0].t - rise_q[0].t, EH);
      chk("wr_post_wait", bfall_q[0].t - fall_q[0].t, 1 + wt(rs, d));
      chk("wr_total", bfall_q[0].t - at, S + EH + 1 + wt(rs, d));
    end
  endtask

  initial begin
    int base, n;
    logic rs_r;
    logic [7:0] d_r;

    // Reset state
    step(3);
    chk("rst_e", lcd_e, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_data", lcd_data, 8'h00);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 1);
    chk("rst_init_done", init_done, 0);
    chk("rst_ten", timer_enable, 0);

    // Initialisation after release
    clear_q();
    base = tcnt;
    rst = 1'b1;
    step(1);
    chk("ten_after_release", timer_enable, 1);
    check_init(base);

    // Directed data write, then clear command
    step(3);
    write_and_check(1'b1, 8'h41, 1'b0);
    step(2);
    write_and_check(1'b0, 8'h01, 1'b0);

    // Second request held while busy is served on the first IDLE cycle
    step(1);
    clear_q();
    req = 1'b1; req_rs = 1'b0; req_data = 8'h02;
    step(1);
    req = 1'b0;
    step(3);
    req = 1'b1; req_rs = 1'b1; req_data = 8'h7E;
    wait_bfall(1, 500);
    chk("held_no_early_ack", ack_q.size(), 1);
    step(1);
    chk("held_ack", ack, 1);
    req = 1'b0;
    if (ack_q.size() == 2 && bfall_q.size() >= 1)
      chk("held_ack_cycle", ack_q[1].cyc - bfall_q[0].cyc, 1);
    wait_bfall(2, 500);
    if (rise_q.size() == 2) begin
      chk("held_first_wait", bfall_q[0].t - fall_q[0].t, 1 + C);
      chk("held_second_data", rise_q[1].d, 8'h7E);
    end

    // Ticks stopped in SETUP
    step(2);
    write_and_check(1'b1, 8'hA5, 1'b1);

    // Random writes with random idle gaps
    for (int i = 0; i < 12; i++) begin
      step($urandom_range(1, 7));
      rs_r = 1'($urandom_range(0, 1));
      d_r  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom);
      write_and_check(rs_r, d_r, 1'b0);
    end

    // Reset while E is high, with a request held through the new init
    step(2);
    clear_q();
    req = 1'b1; req_rs = 1'b1; req_data = 8'h33;
    step(1);
    req = 1'b0;
    n = 0;
    while (!lcd_e && n < 200) begin
      step(1);
      n++;
    end
    chk("mid_write_e_seen", lcd_e, 1);
    rst = 1'b0;
    step(1);
    chk("midrst_e", lcd_e, 0);
    chk("midrst_data", lcd_data, 8'h00);
    chk("midrst_init_done", init_done, 0);
    chk("midrst_busy", busy, 1);
    chk("midrst_ten", timer_enable, 0);
    req = 1'b1; req_rs = 1'b1; req_data = 8'h5A;
    step(2);
    clear_q();
    base = tcnt;
    rst = 1'b1;
    step(1);
    check_init(base);
    step(1);
    chk("held_init_ack", ack, 1);
    req = 1'b0;
    if (ack_q.size() == 1 && bfall_q.size() >= 1)
      chk("held_init_ack_cycle", ack_q[0].cyc - bfall_q[0].cyc, 1);
    wait_bfall(2, 500);
    if (rise_q.size() == 7) chk("held_init_data", rise_q[6].d, 8'h5A);
    step(20);
    chk("held_init_one_ack", ack_q.size(), 1);

    chk("rw_always_low", rw_bad, 0);
    chk("ack_only_from_idle", ack_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
